// File: rtl/ipml_wr_skid_buf_v1_0_if.sv
// ipml_wr_skid_buf_v1_0_if
//   Bundles the upstream valid/ready stream, the FIFO write port and the stall statistics
//   of the ipml write-side skid buffer.
//   Signals:
//     in_data / in_valid / in_ready  upstream stream (in_ready driven by the buffer)
//     wr_data / wr_en / wr_vld       FIFO write port (wr_vld = ~wr_full, driven by the FIFO)
//     stall_clr / stall_cnt          stall counter clear and value
//   Modports:
//     slave   the buffer's view
//     master  the environment's view (upstream producer plus FIFO)
interface ipml_wr_skid_buf_v1_0_if #(
    parameter int unsigned c_WR_DATA_WIDTH = 32,
    parameter int unsigned c_CNT_WIDTH     = 16
) ();
    logic [c_WR_DATA_WIDTH-1:0] in_data;
    logic                       in_valid;
    logic                       in_ready;
    logic [c_WR_DATA_WIDTH-1:0] wr_data;
    logic                       wr_en;
    logic                       wr_vld;
    logic                       stall_clr;
    logic [c_CNT_WIDTH-1:0]     stall_cnt;

    modport slave (
        input  in_data, in_valid, wr_vld, stall_clr,
        output in_ready, wr_data, wr_en, stall_cnt
    );

    modport master (
        output in_data, in_valid, wr_vld, stall_clr,
        input  in_ready, wr_data, wr_en, stall_cnt
    );
endinterface

// File: rtl/ipml_wr_skid_buf_v1_0.sv
// ipml_wr_skid_buf_v1_0
//   Write-side stream adapter in front of an ipml FIFO. Holds up to two beats so that the
//   upstream in_ready is a plain register with no combinational path from the FIFO's wr_vld.
//   Beats accepted at edge N appear on wr_en/wr_data in cycle N+1 (no bypass); order is kept.
//   Ports:
//     wr_clk  single clock
//     wr_rst  asynchronous reset, active high
//     bus     ipml_wr_skid_buf_v1_0_if.slave (stream in, FIFO write port out, stall stats)
//   Configuration:
//     IPML_WR_SKID_STAT_EN  when defined, stall_cnt counts wr_en & ~wr_vld cycles (saturating,
//                           stall_clr has priority); otherwise stall_cnt is 0 and stall_clr unused.
module ipml_wr_skid_buf_v1_0 #(
    parameter int unsigned c_WR_DATA_WIDTH = 32,
    parameter int unsigned c_CNT_WIDTH     = 16
) (
    input  logic                   wr_clk,
    input  logic                   wr_rst,
    ipml_wr_skid_buf_v1_0_if.slave bus
);

    typedef enum logic [1:0] {
        StEmpty = 2'd0,
        StOne   = 2'd1,
        StTwo   = 2'd2
    } state_e;

    state_e                     state_q, state_d;
    logic                       in_ready_q;
    logic                       wr_ptr_q, rd_ptr_q;
    logic [c_WR_DATA_WIDTH-1:0] slot_q [2];

    logic push, pop;

    assign push = bus.in_valid & in_ready_q;
    assign pop  = (state_q != StEmpty) & bus.wr_vld;

    // Occupancy next state
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StEmpty: begin
                if (push) state_d = StOne;
            end
            StOne: begin
                if (push && !pop)      state_d = StTwo;
                else if (pop && !push) state_d = StEmpty;
            end
            StTwo: begin
                if (pop) state_d = StOne;
            end
            default: state_d = StEmpty;
        endcase
    end

    always_ff @(posedge wr_clk or posedge wr_rst) begin
        if (wr_rst) begin
            state_q    <= StEmpty;
            in_ready_q <= 1'b0;
            wr_ptr_q   <= 1'b0;
            rd_ptr_q   <= 1'b0;
            slot_q[0]  <= '0;
            slot_q[1]  <= '0;
        end else begin
            state_q <= state_d;
            // Registered from the next occupancy so a full buffer never accepts a third beat
            in_ready_q <= (state_d != StTwo);
            if (push) begin
                slot_q[wr_ptr_q] <= bus.in_data;
                wr_ptr_q         <= ~wr_ptr_q;
            end
            if (pop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
        end
    end

    assign bus.in_ready = in_ready_q;
    assign bus.wr_en    = (state_q != StEmpty);
    assign bus.wr_data  = slot_q[rd_ptr_q];

`ifdef IPML_WR_SKID_STAT_EN
    logic [c_CNT_WIDTH-1:0] stall_q, stall_d;

    always_comb begin
        stall_d = stall_q;
        if (bus.stall_clr) begin
            stall_d = '0;
        end else if (bus.wr_en && !bus.wr_vld && !(&stall_q)) begin
            stall_d = stall_q + c_CNT_WIDTH'(1);
        end
    end

    always_ff @(posedge wr_clk or posedge wr_rst) begin
        if (wr_rst) begin
            stall_q <= '0;
        end else begin
            stall_q <= stall_d;
        end
    end

    assign bus.stall_cnt = stall_q;
`else
    logic unused_stall_clr;
    assign unused_stall_clr = bus.stall_clr;
    assign bus.stall_cnt    = '0;
`endif

endmodule

// File: tb/tb_ipml_wr_skid_buf_v1_0.sv
// tb_ipml_wr_skid_buf_v1_0
//   Self-checking bench for ipml_wr_skid_buf_v1_0. A queue holds the beats the buffer should
//   currently own; its size gives the expected in_ready/wr_en and its head the expected wr_data.
//   Optional stall statistics follow IPML_WR_SKID_STAT_EN.
module tb_ipml_wr_skid_buf_v1_0;

    localparam int unsigned DW = 32;
    localparam int unsigned CW = 4;

    logic wr_clk;
    logic wr_rst;

    ipml_wr_skid_buf_v1_0_if #(.c_WR_DATA_WIDTH(DW), .c_CNT_WIDTH(CW)) bus ();

    ipml_wr_skid_buf_v1_0 #(
        .c_WR_DATA_WIDTH(DW),
        .c_CNT_WIDTH    (CW)
    ) dut (
        .wr_clk(wr_clk),
        .wr_rst(wr_rst),
        .bus   (bus.slave)
    );

    initial wr_clk = 1'b0;
    always #5 wr_clk = ~wr_clk;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    // Reference state
    logic [DW-1:0] q[$];
    logic          exp_ready;
    int unsigned   exp_stall;
    logic          last_push;
    int unsigned   n_pops;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // One clock: check outputs mid-cycle, then advance the reference across the edge.
    task automatic cycle();
        logic push, pop;
        @(negedge wr_clk);
        chk("in_ready", bus.in_ready, exp_ready);
        chk("wr_en", bus.wr_en, q.size() != 0);
        if (q.size() != 0) chk("wr_data", bus.wr_data, q[0]);
        chk("stall_cnt", bus.stall_cnt, exp_stall);
        push = bus.in_valid && exp_ready;
        pop  = (q.size() != 0) && bus.wr_vld;
`ifdef IPML_WR_SKID_STAT_EN
        if (bus.stall_clr) exp_stall = 0;
        else if (q.size() != 0 && !bus.wr_vld && exp_stall < (1 << CW) - 1) exp_stall++;
`endif
        @(posedge wr_clk);
        if (pop) begin
            void'(q.pop_front());
            n_pops++;
        end
        if (push) q.push_back(bus.in_data);
        exp_ready = (q.size() != 2);
        last_push = push;
        #1;
    endtask

    task automatic do_reset();
        wr_rst       = 1'b1;
        bus.in_valid = 1'b0;
        bus.stall_clr = 1'b0;
        #1;
        chk("rst_wr_en_async", bus.wr_en, 1'b0);
        for (int i = 0; i < 3; i++) begin
            @(negedge wr_clk);
            chk("rst_in_ready", bus.in_ready, 1'b0);
            chk("rst_wr_en", bus.wr_en, 1'b0);
            chk("rst_wr_data", bus.wr_data, '0);
            chk("rst_stall", bus.stall_cnt, '0);
        end
        @(posedge wr_clk);
        #1;
        wr_rst = 1'b0;
        q.delete();
        exp_ready = 1'b0;
        exp_stall = 0;
    endtask

    initial begin
        logic [DW-1:0] bp_beats [3];
        int unsigned   idx;
        int unsigned   sent;
        int unsigned   cyc;

        wr_rst        = 1'b0;
        bus.in_data   = '0;
        bus.in_valid  = 1'b0;
        bus.wr_vld    = 1'b0;
        bus.stall_clr = 1'b0;
        exp_ready     = 1'b0;
        exp_stall     = 0;
        n_pops        = 0;
        last_push     = 1'b0;
        #2;

        // Reset and first edge after release
        do_reset();
        cycle();
        chk("ready_after_rst", bus.in_ready, 1'b1);

        // Single beat
        bus.wr_vld   = 1'b1;
        bus.in_valid = 1'b1;
        bus.in_data  = 32'hA5A5_0001;
        cycle();
        bus.in_valid = 1'b0;
        bus.in_data  = $urandom;
        chk("single_wr_en", bus.wr_en, 1'b1);
        chk("single_data", bus.wr_data, 32'hA5A5_0001);
        cycle();
        chk("single_wr_en_off", bus.wr_en, 1'b0);
        cycle();

        // Streaming 0..255
        n_pops = 0;
        idx    = 0;
        bus.wr_vld = 1'b1;
        while (idx < 256) begin
            bus.in_valid = 1'b1;
            bus.in_data  = idx;
            cycle();
            if (last_push) idx++;
            else chk("stream_stall", 1'b0, 1'b1);
        end
        bus.in_valid = 1'b0;
        for (int i = 0; i < 4; i++) cycle();
        chk("stream_writes", n_pops, 256);

        // Backpressure: three beats offered with FIFO full
        bp_beats[0] = 32'h1111_0000;
        bp_beats[1] = 32'h2222_0000;
        bp_beats[2] = 32'h3333_0000;
        idx = 0;
        bus.wr_vld = 1'b0;
        for (int i = 0; i < 4; i++) begin
            bus.in_valid = 1'b1;
            bus.in_data  = bp_beats[idx];
            cycle();
            if (last_push && idx < 2) idx++;
        end
        chk("bp_accepted", q.size(), 2);
        chk("bp_ready_low", bus.in_ready, 1'b0);
        chk("bp_head_held", bus.wr_data, 32'h1111_0000);
        bus.wr_vld = 1'b1;
        cyc = 0;
        while (!(last_push && bus.in_data == bp_beats[2]) && cyc < 10) begin
            bus.in_valid = 1'b1;
            bus.in_data  = bp_beats[idx];
            cycle();
            if (last_push && idx < 2 && bus.in_data != bp_beats[2]) idx++;
            cyc++;
        end
        chk("bp_third_taken", cyc < 10, 1'b1);
        bus.in_valid = 1'b0;
        for (int i = 0; i < 4; i++) cycle();

        // Stall statistics
        bus.wr_vld   = 1'b0;
        bus.in_valid = 1'b1;
        bus.in_data  = 32'hDEAD_BEEF;
        cycle();
        bus.in_valid = 1'b0;
        for (int i = 0; i < 20; i++) cycle();
`ifdef IPML_WR_SKID_STAT_EN
        chk("stall_sat", bus.stall_cnt, 15);
`else
        chk("stall_off", bus.stall_cnt, 0);
`endif
        bus.stall_clr = 1'b1;
        cycle();
        bus.stall_clr = 1'b0;
        chk("stall_clr", bus.stall_cnt, 0);
        bus.wr_vld = 1'b1;
        for (int i = 0; i < 3; i++) cycle();

        // Random traffic, 10k beats
        sent = 0;
        cyc  = 0;
        while (sent < 10000 && cyc < 60000) begin
            bus.in_valid = ($urandom_range(99) < 70);
            bus.in_data  = $urandom;
            bus.wr_vld   = ($urandom_range(99) < 50);
            bus.stall_clr = ($urandom_range(99) < 3);
            cycle();
            if (last_push) sent++;
            cyc++;
        end
        chk("rand_sent", sent, 10000);
        bus.in_valid  = 1'b0;
        bus.stall_clr = 1'b0;
        bus.wr_vld    = 1'b1;
        for (int i = 0; i < 4; i++) cycle();
        chk("rand_drained", q.size(), 0);

        // Reset while holding two beats
        bus.wr_vld = 1'b0;
        for (int i = 0; i < 3; i++) begin
            bus.in_valid = 1'b1;
            bus.in_data  = $urandom;
            cycle();
        end
        chk("pre_rst_full", q.size(), 2);
        chk("pre_rst_wr_en", bus.wr_en, 1'b1);
        do_reset();
        bus.wr_vld = 1'b1;
        for (int i = 0; i < 4; i++) cycle();
        chk("post_rst_wr_en", bus.wr_en, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
